// File: rtl/flaf_pkg.sv
// flaf_pkg: shared definitions for the FLAF dot-product scheduling slice.
// Holds the scheduler FSM state encoding, clog2-based width helpers for the
// block-index and block-count ports, and the default dot-product unit latency.
package flaf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  // Block index width; never narrower than one bit so a single-block
  // configuration still has a port.
  function automatic int addr_w(input int nblk_max);
    return (nblk_max > 1) ? $clog2(nblk_max) : 1;
  endfunction

  // Block-count width; must be able to hold nblk_max itself.
  function automatic int nblk_w(input int nblk_max);
    return $clog2(nblk_max + 1);
  endfunction

  // The adder tree sums all LEN products combinationally and registers once.
  function automatic int tree_lat(input int len);
    return (len > 1) ? 1 : 0;
  endfunction

  localparam int LEN_DEF      = 8;
  localparam int NBLK_MAX_DEF = 4;
  // Multiplier register + adder tree + output retiming register.
  localparam int DOTP_LAT_DEF = 2 + tree_lat(LEN_DEF);

endpackage

// File: rtl/DelayNUnit.sv
// DelayNUnit: W-bit wide, N-cycle delay line (shift register) with a
// synchronous active-high clear.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous clear of every stage
//   din   - value entering the line
//   dout  - din delayed by N cycles
module DelayNUnit #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [N-1:0][W-1:0] sr;

  if (N == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (reset) sr <= '0;
      else       sr[0] <= din;
    end
  end else begin : g_many
    always_ff @(posedge clk) begin
      if (reset) sr <= '0;
      else       sr <= {sr[N-2:0], din};
    end
  end

  assign dout = sr[N-1];

endmodule

// File: rtl/dotp_block_scheduler.sv
// dotp_block_scheduler: time-multiplexes one pipelined LEN-wide dot-product
// unit over up to NBLK_MAX operand blocks, one block per cycle, and
// accumulates the returned partial sums into a single WIDTH-bit result.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - job request, only looked at in IDLE
//   nblk       - blocks in the job (clamped to NBLK_MAX), sampled with start
//   dotp_in    - dot-product unit output, DOTP_LAT cycles behind blk_addr
//   issue      - blk_addr carries a valid block this cycle
//   blk_addr   - operand block index to the operand muxes (0 when idle)
//   busy       - job in progress, acceptance through done inclusive
//   done       - one-cycle pulse, acc_out valid from this cycle
//   acc_out    - final wrap-around sum, held until the next done
module dotp_block_scheduler
  import flaf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int QP       = 12,
  parameter int LEN      = LEN_DEF,
  parameter int NBLK_MAX = NBLK_MAX_DEF,
  parameter int DOTP_LAT = 2 + tree_lat(LEN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [nblk_w(NBLK_MAX)-1:0] nblk,
  input  logic [WIDTH-1:0]            dotp_in,
  output logic                        issue,
  output logic [addr_w(NBLK_MAX)-1:0] blk_addr,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            acc_out
);

  localparam int AW = addr_w(NBLK_MAX);
  localparam int NW = nblk_w(NBLK_MAX);

  // QP only documents the number format; the sum is a plain wrap-around add.
  if (QP < 0 || QP >= WIDTH || NBLK_MAX < 1 || DOTP_LAT < 1) begin : g_bad_params
    $error("dotp_block_scheduler: unsupported parameter combination");
  end

  sched_state_t      state, state_nx;
  logic [AW-1:0]     last_addr;
  logic [NW-1:0]     nblk_clamp;
  logic [NW-1:0]     pend;
  logic [WIDTH-1:0]  acc, acc_nx;
  logic              tag_out;
  logic              accept;
  logic              last_blk;
  logic              drained;

  // Tag pipe: marks which dotp_in cycles belong to an issued block.
  DelayNUnit #(1, DOTP_LAT) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (issue),
    .dout  (tag_out)
  );

  assign issue = (state == S_ISSUE);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  assign accept     = (state == S_IDLE) && start;
  assign nblk_clamp = (nblk > NW'(NBLK_MAX)) ? NW'(NBLK_MAX) : nblk;
  assign last_blk   = (blk_addr == last_addr);
  assign acc_nx     = tag_out ? (acc + dotp_in) : acc;

  // pend counts issued blocks whose result has not yet been summed. The job
  // is complete once the only outstanding result is the one arriving now, so
  // DONE is entered on the same edge that absorbs the final partial sum.
  assign drained = (pend == '0) || ((pend == NW'(1)) && tag_out);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (nblk == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_blk) state_nx = S_DRAIN;
      S_DRAIN: if (drained) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      blk_addr  <= '0;
      last_addr <= '0;
      pend      <= '0;
      acc       <= '0;
      acc_out   <= '0;
    end else begin
      state    <= state_nx;
      acc      <= accept ? '0 : acc_nx;
      blk_addr <= (issue && !last_blk) ? blk_addr + AW'(1) : '0;

      if (accept) last_addr <= AW'(nblk_clamp - NW'(1));

      case ({issue, tag_out})
        2'b10:   pend <= pend + NW'(1);
        2'b01:   pend <= pend - NW'(1);
        default: pend <= pend;
      endcase

      // acc_out must include the partial sum absorbed on this same edge; a
      // zero-block job reports zero regardless of the previous accumulator.
      if (state_nx == S_DONE) acc_out <= accept ? '0 : acc_nx;
    end
  end

endmodule

// File: tb/tb_dotp_block_scheduler.sv
// Bench for dotp_block_scheduler with a behavioural DOTP_LAT-cycle dot-product
// unit model. Expected job results go into a queue when a job is started and
// are popped when done is seen.
module tb_dotp_block_scheduler;

  localparam int DL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  nblk = '0;
  logic [15:0] dotp_in;
  logic        issue;
  logic [1:0]  blk_addr;
  logic        busy;
  logic        done;
  logic [15:0] acc_out;

  logic [15:0] blk_val [4];
  logic [15:0] exp_q [$];
  logic [15:0] last_acc = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  // Unit model: value of the issued block appears DL cycles later, filler
  // 0x7FFF on every other cycle.
  logic [DL-1:0]       mv = '0;
  logic [DL-1:0][15:0] md = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mv <= {mv[DL-2:0], issue};
    md <= {md[DL-2:0], blk_val[blk_addr]};
  end
  assign dotp_in = mv[DL-1] ? md[DL-1] : 16'h7FFF;

  dotp_block_scheduler #(
    .WIDTH(16), .QP(12), .LEN(8), .NBLK_MAX(4), .DOTP_LAT(DL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nblk     (nblk),
    .dotp_in  (dotp_in),
    .issue    (issue),
    .blk_addr (blk_addr),
    .busy     (busy),
    .done     (done),
    .acc_out  (acc_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from its start cycle (cycle 0) through its done cycle,
  // checking every cycle; returns positioned in the cycle after done.
  task automatic run_job(input int n, input logic [15:0] v0, v1, v2, v3,
                         input bit hold, input string nm);
    int          nc, last_cyc;
    logic [15:0] e;
    logic        e_iss, e_busy, e_done;
    logic [1:0]  e_addr;
    blk_val[0] = v0; blk_val[1] = v1; blk_val[2] = v2; blk_val[3] = v3;
    nc = (n > 4) ? 4 : n;
    e = '0;
    for (int i = 0; i < nc; i++) e = e + blk_val[i];
    exp_q.push_back(e);
    last_cyc = (n == 0) ? 1 : nc + DL + 1;
    nblk  = 3'(n);
    start = 1'b1;
    for (int c = 0; c <= last_cyc; c++) begin
      e_iss  = (c >= 1) && (c <= nc);
      e_addr = e_iss ? 2'(c - 1) : 2'd0;
      e_busy = (c >= 1) && (c <= last_cyc);
      e_done = (c == last_cyc);
      n_chk++;
      if (issue !== e_iss) begin
        n_fail++;
        $display("FAIL %s issue c%0d: got %b want %b", nm, c, issue, e_iss);
      end
      n_chk++;
      if (blk_addr !== e_addr) begin
        n_fail++;
        $display("FAIL %s blk_addr c%0d: got %0d want %0d", nm, c, blk_addr, e_addr);
      end
      n_chk++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy c%0d: got %b want %b", nm, c, busy, e_busy);
      end
      n_chk++;
      if (done !== e_done) begin
        n_fail++;
        $display("FAIL %s done c%0d: got %b want %b", nm, c, done, e_done);
      end
      if (done === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s acc_out c%0d: got %h want no result", nm, c, acc_out);
        end else begin
          e = exp_q.pop_front();
          if (acc_out !== e) begin
            n_fail++;
            $display("FAIL %s acc_out c%0d: got %h want %h", nm, c, acc_out, e);
          end
          last_acc = e;
        end
      end else begin
        n_chk++;
        if (acc_out !== last_acc) begin
          n_fail++;
          $display("FAIL %s acc_hold c%0d: got %h want %h", nm, c, acc_out, last_acc);
        end
      end
      step();
      if (!hold) start = 1'b0;
    end
  endtask

  task automatic idle(input int k, input string nm);
    start = 1'b0;
    for (int c = 0; c < k; c++) begin
      n_chk++;
      if ({issue, busy, done} !== 3'b000 || blk_addr !== 2'd0) begin
        n_fail++;
        $display("FAIL %s idle c%0d: got issue/busy/done %b%b%b addr %0d want 0000",
                 nm, c, issue, busy, done, blk_addr);
      end
      n_chk++;
      if (acc_out !== last_acc) begin
        n_fail++;
        $display("FAIL %s idle_acc c%0d: got %h want %h", nm, c, acc_out, last_acc);
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    nblk  = 3'd2;
    step();
    step();
    n_chk++;
    if (issue !== 1'b0 || blk_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset issue/addr: got %b/%0d want 0/0", issue, blk_addr);
    end
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done);
    end
    n_chk++;
    if (acc_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset acc_out: got %h want 0000", acc_out);
    end
    start = 1'b0;
    reset = 1'b0;
    step();
    idle(2, "post_reset");
  endtask

  task automatic test_basic();
    run_job(4, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, "basic");
    idle(2, "basic");
  endtask

  task automatic test_wrap();
    run_job(4, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 1'b0, "wrap4");
    idle(1, "wrap4");
    run_job(2, 16'hF000, 16'h0800, 16'h1111, 16'h2222, 1'b0, "wrap2");
    idle(1, "wrap2");
  endtask

  task automatic test_zero_clamp();
    run_job(0, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 1'b0, "zero");
    idle(2, "zero");
    run_job(7, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, "clamp");
    idle(2, "clamp");
  endtask

  task automatic test_back_to_back();
    run_job(3, 16'h0005, 16'h0006, 16'h0007, 16'h0BAD, 1'b1, "b2b_a");
    run_job(2, 16'h1000, 16'h2000, 16'h0BAD, 16'h0BAD, 1'b1, "b2b_b");
    idle(3, "b2b");
  endtask

  task automatic test_reset_mid();
    blk_val[0] = 16'h1000; blk_val[1] = 16'h2000;
    blk_val[2] = 16'h3000; blk_val[3] = 16'h4000;
    nblk  = 3'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    n_chk++;
    if (busy !== 1'b0 || issue !== 1'b0 || done !== 1'b0 || blk_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid ctl: got busy %b issue %b done %b addr %0d want 0",
               busy, issue, done, blk_addr);
    end
    n_chk++;
    if (acc_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid acc_out: got %h want 0000", acc_out);
    end
    reset    = 1'b0;
    last_acc = 16'h0000;
    run_job(1, 16'h0123, 16'h0BAD, 16'h0BAD, 16'h0BAD, 1'b0, "after_reset");
    idle(4, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) blk_val[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_clamp();
    test_back_to_back();
    test_reset_mid();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
